// File: rtl/cache_refill_arbiter.sv
// Refill sequencer shared by the I-cache and D-cache in front of a single
// main-memory read port. Misses are arbitrated round-robin. The winner gets
// a block-aligned 64-bit read, then a one-cycle fill strobe carrying the block.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   I_MISS/I_ADDR              I-cache miss level and miss address
//   D_MISS/D_ADDR              D-cache miss level and miss address
//   MM_REQ/MM_ADDR             memory read request (held until MM_ACK), block address
//   MM_ACK/MM_RDATA            one-cycle acknowledge with block data
//   I_ACCESS_MM/D_ACCESS_MM    one-cycle fill strobes to each cache
//   FILL_DATA                  registered block, valid while a strobe is high
//   BUSY                       arbiter not idle
//   ERR                        sticky memory-timeout flag
//   CNT_REFILL_I/CNT_REFILL_D  completed refill counters (wrapping)
module cache_refill_arbiter #(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_MISS,
    input  logic [31:0]      I_ADDR,
    input  logic             D_MISS,
    input  logic [31:0]      D_ADDR,
    output logic             MM_REQ,
    output logic [31:0]      MM_ADDR,
    input  logic             MM_ACK,
    input  logic [63:0]      MM_RDATA,
    output logic             I_ACCESS_MM,
    output logic             D_ACCESS_MM,
    output logic [63:0]      FILL_DATA,
    output logic             BUSY,
    output logic             ERR,
    output logic [CNT_W-1:0] CNT_REFILL_I,
    output logic [CNT_W-1:0] CNT_REFILL_D
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_MASK
    } state_e;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } side_e;

    // Last REQ cycle index; the request is held for exactly MAX_WAIT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    side_e            last_gnt_q, last_gnt_d;
    side_e            gnt_q, gnt_d;
    logic             mask_ic_q, mask_ic_d;
    logic             mask_dc_q, mask_dc_d;
    logic [7:0]       wait_q, wait_d;
    logic             mm_req_q, mm_req_d;
    logic [31:0]      mm_addr_q, mm_addr_d;
    logic [63:0]      fill_data_q, fill_data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_ic_q, cnt_ic_d;
    logic [CNT_W-1:0] cnt_dc_q, cnt_dc_d;

    logic             req_ic;
    logic             req_dc;
    side_e            pick;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= SIDE_D;
            gnt_q       <= SIDE_I;
            mask_ic_q   <= 1'b0;
            mask_dc_q   <= 1'b0;
            wait_q      <= '0;
            mm_req_q    <= 1'b0;
            mm_addr_q   <= '0;
            fill_data_q <= '0;
            err_q       <= 1'b0;
            cnt_ic_q    <= '0;
            cnt_dc_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            mask_ic_q   <= mask_ic_d;
            mask_dc_q   <= mask_dc_d;
            wait_q      <= wait_d;
            mm_req_q    <= mm_req_d;
            mm_addr_q   <= mm_addr_d;
            fill_data_q <= fill_data_d;
            err_q       <= err_d;
            cnt_ic_q    <= cnt_ic_d;
            cnt_dc_q    <= cnt_dc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        mask_ic_d   = mask_ic_q;
        mask_dc_d   = mask_dc_q;
        wait_d      = wait_q;
        mm_req_d    = mm_req_q;
        mm_addr_d   = mm_addr_q;
        fill_data_d = fill_data_q;
        err_d       = err_q;
        cnt_ic_d    = cnt_ic_q;
        cnt_dc_d    = cnt_dc_q;
        req_ic      = I_MISS & ~mask_ic_q;
        req_dc      = D_MISS & ~mask_dc_q;
        pick        = SIDE_I;

        case (state_q)
            S_IDLE: begin
                if (req_ic || req_dc) begin
                    // On a tie the side that did not win last time goes first.
                    if (req_ic && req_dc) begin
                        pick = (last_gnt_q == SIDE_I) ? SIDE_D : SIDE_I;
                    end else begin
                        pick = req_ic ? SIDE_I : SIDE_D;
                    end
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    mm_addr_d  = ((pick == SIDE_I) ? I_ADDR : D_ADDR) & 32'hFFFF_FFF8;
                    mm_req_d   = 1'b1;
                    wait_d     = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (MM_ACK) begin
                    fill_data_d = MM_RDATA;
                    mm_req_d    = 1'b0;
                    state_d     = S_FILL;
                end else if (wait_q == WAIT_LAST) begin
                    err_d    = 1'b1;
                    mm_req_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_FILL: begin
                if (gnt_q == SIDE_I) begin
                    cnt_ic_d  = cnt_ic_q + 1'b1;
                    mask_ic_d = 1'b1;
                end else begin
                    cnt_dc_d  = cnt_dc_q + 1'b1;
                    mask_dc_d = 1'b1;
                end
                state_d = S_MASK;
            end
            S_MASK: begin
                // The served cache still shows its miss this cycle; hold off one cycle.
                mask_ic_d = 1'b0;
                mask_dc_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign MM_REQ       = mm_req_q;
    assign MM_ADDR      = mm_addr_q;
    assign FILL_DATA    = fill_data_q;
    assign I_ACCESS_MM  = (state_q == S_FILL) && (gnt_q == SIDE_I);
    assign D_ACCESS_MM  = (state_q == S_FILL) && (gnt_q == SIDE_D);
    assign BUSY         = (state_q != S_IDLE);
    assign ERR          = err_q;
    assign CNT_REFILL_I = cnt_ic_q;
    assign CNT_REFILL_D = cnt_dc_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Self-checking bench for cache_refill_arbiter. Expected fills are queued
// when misses are raised and popped when the DUT strobes a fill.
module tb_cache_refill_arbiter;

    localparam int CNT_W = 20;

    logic             CLK;
    logic             RESET;
    logic             I_MISS;
    logic [31:0]      I_ADDR;
    logic             D_MISS;
    logic [31:0]      D_ADDR;
    logic             MM_REQ;
    logic [31:0]      MM_ADDR;
    logic             MM_ACK;
    logic [63:0]      MM_RDATA;
    logic             I_ACCESS_MM;
    logic             D_ACCESS_MM;
    logic [63:0]      FILL_DATA;
    logic             BUSY;
    logic             ERR;
    logic [CNT_W-1:0] CNT_REFILL_I;
    logic [CNT_W-1:0] CNT_REFILL_D;

    typedef struct {
        logic        side_d;
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt_i;
    logic [CNT_W-1:0] exp_cnt_d;
    logic [63:0]      last_fill;

    cache_refill_arbiter #(
        .MAX_WAIT(8),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .I_MISS      (I_MISS),
        .I_ADDR      (I_ADDR),
        .D_MISS      (D_MISS),
        .D_ADDR      (D_ADDR),
        .MM_REQ      (MM_REQ),
        .MM_ADDR     (MM_ADDR),
        .MM_ACK      (MM_ACK),
        .MM_RDATA    (MM_RDATA),
        .I_ACCESS_MM (I_ACCESS_MM),
        .D_ACCESS_MM (D_ACCESS_MM),
        .FILL_DATA   (FILL_DATA),
        .BUSY        (BUSY),
        .ERR         (ERR),
        .CNT_REFILL_I(CNT_REFILL_I),
        .CNT_REFILL_D(CNT_REFILL_D)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Memory responder (stimulus only): waits for MM_REQ, holds ACK off for
    // ack_delay cycles, pulses ACK with data, then samples the fill cycle.
    task automatic run_txn(input int ack_delay, input logic [63:0] data,
                           output bit got_req, output int req_wait, output bit held,
                           output logic [31:0] addr_seen, output logic s_i,
                           output logic s_d, output logic [63:0] fill_seen);
        got_req   = 1'b0;
        req_wait  = 0;
        held      = 1'b1;
        addr_seen = '0;
        s_i       = 1'b0;
        s_d       = 1'b0;
        fill_seen = '0;
        for (int c = 0; c < 40 && !got_req; c++) begin
            @(negedge CLK);
            req_wait++;
            if (MM_REQ) got_req = 1'b1;
        end
        if (!got_req) return;
        addr_seen = MM_ADDR;
        for (int c = 0; c < ack_delay; c++) begin
            @(negedge CLK);
            if (!MM_REQ || MM_ADDR !== addr_seen) held = 1'b0;
        end
        MM_ACK   = 1'b1;
        MM_RDATA = data;
        @(negedge CLK);
        MM_ACK    = 1'b0;
        MM_RDATA  = '0;
        s_i       = I_ACCESS_MM;
        s_d       = D_ACCESS_MM;
        fill_seen = FILL_DATA;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        I_MISS   = 1'b0;
        D_MISS   = 1'b0;
        I_ADDR   = '0;
        D_ADDR   = '0;
        MM_ACK   = 1'b0;
        MM_RDATA = '0;
        sb.delete();
        exp_cnt_i = '0;
        exp_cnt_d = '0;
        last_fill = '0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY, ERR} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY, ERR});
        end
        n_cmp++;
        if (MM_ADDR !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr: got %h expected 0", MM_ADDR);
        end
        n_cmp++;
        if (FILL_DATA !== 64'h0) begin
            n_err++;
            $display("FAIL reset_fill: got %h expected 0", FILL_DATA);
        end
        n_cmp++;
        if ({CNT_REFILL_I, CNT_REFILL_D} !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", CNT_REFILL_I, CNT_REFILL_D);
        end
        RESET = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({MM_REQ, BUSY} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got %b expected 00", {MM_REQ, BUSY});
        end
    endtask

    task automatic test_single_i();
        exp_t        e;
        bit          got_req, held;
        int          req_wait;
        logic [31:0] addr_seen;
        logic        s_i, s_d;
        logic [63:0] fill_seen;
        I_ADDR = 32'h0000_0014;
        I_MISS = 1'b1;
        sb.push_back('{1'b0, I_ADDR & 32'hFFFF_FFF8, 64'hAAAA_BBBB_CCCC_DDDD});
        e = sb.pop_front();
        run_txn(2, e.data, got_req, req_wait, held, addr_seen, s_i, s_d, fill_seen);
        I_MISS = 1'b0;
        exp_cnt_i++;
        last_fill = e.data;
        n_cmp++;
        if (!got_req || req_wait !== 1) begin
            n_err++;
            $display("FAIL single_latency: got req=%0b after %0d cycles expected 1 after 1", got_req, req_wait);
        end
        n_cmp++;
        if (addr_seen !== e.addr || !held) begin
            n_err++;
            $display("FAIL single_addr: got %h held=%0b expected %h held=1", addr_seen, held, e.addr);
        end
        n_cmp++;
        if ({s_i, s_d} !== 2'b10) begin
            n_err++;
            $display("FAIL single_strobe: got i/d=%b expected 10", {s_i, s_d});
        end
        n_cmp++;
        if (fill_seen !== e.data) begin
            n_err++;
            $display("FAIL single_data: got %h expected %h", fill_seen, e.data);
        end
        @(negedge CLK);
        n_cmp++;
        if ({I_ACCESS_MM, D_ACCESS_MM} !== 2'b00) begin
            n_err++;
            $display("FAIL single_pulse_width: got i/d=%b expected 00", {I_ACCESS_MM, D_ACCESS_MM});
        end
        n_cmp++;
        if (CNT_REFILL_I !== exp_cnt_i || CNT_REFILL_D !== exp_cnt_d) begin
            n_err++;
            $display("FAIL single_cnt: got %0d/%0d expected %0d/%0d",
                     CNT_REFILL_I, CNT_REFILL_D, exp_cnt_i, exp_cnt_d);
        end
    endtask

    task automatic test_round_robin();
        exp_t        e;
        bit          got_req, held;
        int          req_wait;
        logic [31:0] addr_seen;
        logic        s_i, s_d;
        logic [63:0] fill_seen;
        logic [1:0]  after_pat [7];
        logic        exp_side [7];
        // {I_MISS, D_MISS} driven at each fill: pairs held, then a lone I, then a fresh pair.
        after_pat = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
        exp_side  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        RESET  = 1'b0;
        I_ADDR = 32'h1000_000E;
        D_ADDR = 32'h2000_001F;
        for (int k = 0; k < 7; k++) begin
            sb.push_back('{exp_side[k],
                           (exp_side[k] ? D_ADDR : I_ADDR) & 32'hFFFF_FFF8,
                           {32'hC0DE_0000 + 32'(k), 32'h0000_F00D + 32'(k)}});
        end
        I_MISS = 1'b1;
        D_MISS = 1'b1;
        for (int k = 0; k < 7; k++) begin
            e = sb.pop_front();
            run_txn(1, e.data, got_req, req_wait, held, addr_seen, s_i, s_d, fill_seen);
            {I_MISS, D_MISS} = after_pat[k];
            if (e.side_d) exp_cnt_d++;
            else          exp_cnt_i++;
            last_fill = e.data;
            n_cmp++;
            if (!got_req || !held || addr_seen !== e.addr) begin
                n_err++;
                $display("FAIL rr_addr[%0d]: got %h req=%0b held=%0b expected %h", k, addr_seen, got_req, held, e.addr);
            end
            n_cmp++;
            if ({s_i, s_d} !== {~e.side_d, e.side_d}) begin
                n_err++;
                $display("FAIL rr_side[%0d]: got i/d=%b expected %b", k, {s_i, s_d}, {~e.side_d, e.side_d});
            end
            n_cmp++;
            if (fill_seen !== e.data) begin
                n_err++;
                $display("FAIL rr_data[%0d]: got %h expected %h", k, fill_seen, e.data);
            end
        end
        @(negedge CLK);
        n_cmp++;
        if (CNT_REFILL_I !== exp_cnt_i || CNT_REFILL_D !== exp_cnt_d) begin
            n_err++;
            $display("FAIL rr_cnt: got %0d/%0d expected %0d/%0d",
                     CNT_REFILL_I, CNT_REFILL_D, exp_cnt_i, exp_cnt_d);
        end
    endtask

    task automatic test_hold_i();
        exp_t        e;
        bit          got_req, held, req_seen;
        int          req_wait;
        logic [31:0] addr_seen;
        logic        s_i, s_d;
        logic [63:0] fill_seen;
        I_ADDR = 32'h0000_4000;
        I_MISS = 1'b1;
        sb.push_back('{1'b0, 32'h0000_4000, 64'h0123_4567_89AB_CDEF});
        sb.push_back('{1'b0, 32'h0000_4000, 64'hFEDC_BA98_7654_3210});
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            run_txn(0, e.data, got_req, req_wait, held, addr_seen, s_i, s_d, fill_seen);
            if (k == 1) I_MISS = 1'b0;
            exp_cnt_i++;
            last_fill = e.data;
            n_cmp++;
            if (!got_req || !held || addr_seen !== e.addr || {s_i, s_d} !== 2'b10 || fill_seen !== e.data) begin
                n_err++;
                $display("FAIL hold_fill[%0d]: got addr=%h i/d=%b data=%h expected addr=%h i/d=10 data=%h",
                         k, addr_seen, {s_i, s_d}, fill_seen, e.addr, e.data);
            end
            if (k == 0) begin
                @(negedge CLK);
                n_cmp++;
                if ({MM_REQ, I_ACCESS_MM, BUSY} !== 3'b001) begin
                    n_err++;
                    $display("FAIL hold_mask_cycle: got req/strobe/busy=%b expected 001", {MM_REQ, I_ACCESS_MM, BUSY});
                end
                @(negedge CLK);
                n_cmp++;
                if ({MM_REQ, BUSY} !== 2'b00) begin
                    n_err++;
                    $display("FAIL hold_idle_cycle: got req/busy=%b expected 00", {MM_REQ, BUSY});
                end
            end
        end
        req_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (MM_REQ) req_seen = 1'b1;
        end
        n_cmp++;
        if (req_seen !== 1'b0) begin
            n_err++;
            $display("FAIL hold_no_regrant: got MM_REQ=1 expected 0 after miss dropped");
        end
        n_cmp++;
        if (CNT_REFILL_I !== exp_cnt_i || CNT_REFILL_D !== exp_cnt_d) begin
            n_err++;
            $display("FAIL hold_cnt: got %0d/%0d expected %0d/%0d",
                     CNT_REFILL_I, CNT_REFILL_D, exp_cnt_i, exp_cnt_d);
        end
    endtask

    task automatic test_stray_ack_idle();
        MM_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;
        MM_ACK   = 1'b1;
        @(negedge CLK);
        MM_ACK   = 1'b0;
        MM_RDATA = '0;
        n_cmp++;
        if (FILL_DATA !== last_fill) begin
            n_err++;
            $display("FAIL stray_idle_data: got %h expected %h", FILL_DATA, last_fill);
        end
        @(negedge CLK);
        n_cmp++;
        if ({MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY} !== 4'b0) begin
            n_err++;
            $display("FAIL stray_idle_state: got req/i/d/busy=%b expected 0000",
                     {MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY});
        end
    endtask

    task automatic test_timeout();
        exp_t        e;
        bit          got_req, held, done, saw_strobe;
        int          req_wait, req_cycles;
        logic        err_before;
        logic [31:0] addr_seen, addr_first;
        logic        s_i, s_d;
        logic [63:0] fill_seen;
        D_ADDR     = 32'h0000_0104;
        D_MISS     = 1'b1;
        req_cycles = 0;
        done       = 1'b0;
        saw_strobe = 1'b0;
        err_before = 1'bx;
        addr_first = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (I_ACCESS_MM || D_ACCESS_MM) saw_strobe = 1'b1;
            if (MM_REQ) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    err_before = ERR;
                    addr_first = MM_ADDR;
                end
            end else if (req_cycles > 0) begin
                done = 1'b1;
            end
        end
        D_MISS = 1'b0;
        n_cmp++;
        if (req_cycles !== 8) begin
            n_err++;
            $display("FAIL timeout_req_len: got %0d cycles expected 8", req_cycles);
        end
        n_cmp++;
        if (addr_first !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL timeout_addr: got %h expected 00000100", addr_first);
        end
        n_cmp++;
        if ({err_before, ERR} !== 2'b01) begin
            n_err++;
            $display("FAIL timeout_err: got before/after=%b expected 01", {err_before, ERR});
        end
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (saw_strobe || MM_REQ || CNT_REFILL_I !== exp_cnt_i || CNT_REFILL_D !== exp_cnt_d) begin
            n_err++;
            $display("FAIL timeout_no_fill: got strobe=%0b req=%0b cnt=%0d/%0d expected 0 0 %0d/%0d",
                     saw_strobe, MM_REQ, CNT_REFILL_I, CNT_REFILL_D, exp_cnt_i, exp_cnt_d);
        end
        I_ADDR = 32'h0000_0A0C;
        I_MISS = 1'b1;
        sb.push_back('{1'b0, 32'h0000_0A08, 64'h5555_6666_7777_8888});
        e = sb.pop_front();
        run_txn(1, e.data, got_req, req_wait, held, addr_seen, s_i, s_d, fill_seen);
        I_MISS = 1'b0;
        exp_cnt_i++;
        last_fill = e.data;
        n_cmp++;
        if (!got_req || req_wait !== 1 || !held || addr_seen !== e.addr || {s_i, s_d} !== 2'b10 || fill_seen !== e.data) begin
            n_err++;
            $display("FAIL timeout_recover: got addr=%h i/d=%b data=%h wait=%0d expected addr=%h i/d=10 data=%h wait=1",
                     addr_seen, {s_i, s_d}, fill_seen, req_wait, e.addr, e.data);
        end
        @(negedge CLK);
        n_cmp++;
        if (ERR !== 1'b1 || CNT_REFILL_I !== exp_cnt_i) begin
            n_err++;
            $display("FAIL timeout_sticky: got err=%0b cnt_i=%0d expected 1 %0d", ERR, CNT_REFILL_I, exp_cnt_i);
        end
    endtask

    task automatic test_reset_mid();
        bit got_req;
        I_ADDR  = 32'h0000_2468;
        I_MISS  = 1'b1;
        got_req = 1'b0;
        for (int c = 0; c < 10 && !got_req; c++) begin
            @(negedge CLK);
            if (MM_REQ) got_req = 1'b1;
        end
        n_cmp++;
        if (got_req !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_req: got MM_REQ=0 expected 1 before reset");
        end
        // Reset arrives together with an ACK; nothing may be captured.
        RESET    = 1'b1;
        MM_ACK   = 1'b1;
        MM_RDATA = 64'hFFFF_0000_FFFF_0000;
        #1;
        exp_cnt_i = '0;
        exp_cnt_d = '0;
        last_fill = '0;
        n_cmp++;
        if ({MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY, ERR} !== 5'b0 || MM_ADDR !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_async: got req/i/d/busy/err=%b addr=%h expected 00000 0",
                     {MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY, ERR}, MM_ADDR);
        end
        n_cmp++;
        if (FILL_DATA !== 64'h0 || CNT_REFILL_I !== exp_cnt_i || CNT_REFILL_D !== exp_cnt_d) begin
            n_err++;
            $display("FAIL reset_mid_clear: got data=%h cnt=%0d/%0d expected 0 0/0",
                     FILL_DATA, CNT_REFILL_I, CNT_REFILL_D);
        end
        I_MISS = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        MM_ACK   = 1'b0;
        MM_RDATA = '0;
        @(negedge CLK);
        n_cmp++;
        if ({MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY} !== 4'b0 || FILL_DATA !== last_fill) begin
            n_err++;
            $display("FAIL reset_mid_stray_ack: got req/i/d/busy=%b data=%h expected 0000 %h",
                     {MM_REQ, I_ACCESS_MM, D_ACCESS_MM, BUSY}, FILL_DATA, last_fill);
        end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_round_robin();
        test_hold_i();
        test_stray_ack_idle();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
